// File: rtl/bp_bedrock_beat_packer_pkg.sv
// Shared BedRock message size encoding and helpers for the beat packer slice.
`default_nettype none

package bp_bedrock_beat_packer_pkg;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'b000,
    e_bedrock_msg_size_2   = 3'b001,
    e_bedrock_msg_size_4   = 3'b010,
    e_bedrock_msg_size_8   = 3'b011,
    e_bedrock_msg_size_16  = 3'b100,
    e_bedrock_msg_size_32  = 3'b101,
    e_bedrock_msg_size_64  = 3'b110,
    e_bedrock_msg_size_128 = 3'b111
  } bp_bedrock_msg_size_e;

  localparam int msg_size_width_gp = $bits(bp_bedrock_msg_size_e);

  // Never returns 0 so that derived vectors are at least one bit wide.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_bedrock_len_to_size.sv
// Combinational encoder from zero-based beat length to BedRock message size.
`default_nettype none

module bp_bedrock_len_to_size
  import bp_bedrock_beat_packer_pkg::*;
#(
  parameter int beat_width_p = 64,
  parameter int len_width_p  = 3
) (
  input  logic [len_width_p-1:0]       len_i,
  input  logic [msg_size_width_gp-1:0] req_size_i,
  output logic [msg_size_width_gp-1:0] size_o
);

  localparam logic [msg_size_width_gp-1:0] beat_size_lp =
    msg_size_width_gp'($clog2(beat_width_p / 8));

  int len_bits;

  // clog2(len+1) equals the bit length of len, so multi-beat counts round up.
  always_comb begin
    len_bits = 0;
    for (int i = 0; i < len_width_p; i++) begin
      if (len_i[i]) len_bits = i + 1;
    end

    if (len_i == '0) begin
      size_o = (req_size_i > beat_size_lp) ? beat_size_lp : req_size_i;
    end else begin
      size_o = beat_size_lp + msg_size_width_gp'(len_bits);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_bedrock_beat_packer.sv
// Packs a stream of data beats into one wide BedRock message buffer and
// derives the message size and zero-based length from the stored beat count.
`default_nettype none

module bp_bedrock_beat_packer
  import bp_bedrock_beat_packer_pkg::*;
#(
  parameter int beat_width_p     = 64,
  parameter int max_data_width_p = 512,
  localparam int max_beats_lp    = max_data_width_p / beat_width_p,
  localparam int len_width_lp    = safe_clog2(max_beats_lp)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [beat_width_p-1:0]       in_data_i,
  input  logic [msg_size_width_gp-1:0]  in_size_i,
  input  logic                          in_last_i,
  input  logic                          in_v_i,
  output logic                          in_ready_and_o,

  output logic [max_data_width_p-1:0]   out_data_o,
  output logic [msg_size_width_gp-1:0]  out_size_o,
  output logic [len_width_lp-1:0]       out_len_o,
  output logic                          out_overflow_o,
  output logic                          out_v_o,
  input  logic                          out_ready_and_i
);

  localparam logic [0:0] e_collect = 1'b0;
  localparam logic [0:0] e_full    = 1'b1;

  // Counter must reach max_beats_lp itself, so it is one state wider than a slot index.
  localparam int cnt_width_lp = $clog2(max_beats_lp + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_beats_lp);

  logic [0:0]                  state_q,    state_d;
  logic [cnt_width_lp-1:0]     count_q,    count_d;
  logic [max_data_width_p-1:0] data_q,     data_d;
  bp_bedrock_msg_size_e        size_q,     size_d;
  logic                        overflow_q, overflow_d;

  logic                        accept;
  logic                        handshake;
  logic [len_width_lp-1:0]     len_lo;

  assign in_ready_and_o = (state_q == e_collect);
  assign out_v_o        = (state_q == e_full);
  assign accept         = in_v_i & in_ready_and_o;
  assign handshake      = out_v_o & out_ready_and_i;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    data_d     = data_q;
    size_d     = size_q;
    overflow_d = overflow_q;

    if (handshake) begin
      state_d    = e_collect;
      count_d    = '0;
      data_d     = '0;
      size_d     = e_bedrock_msg_size_1;
      overflow_d = 1'b0;
    end else if (accept) begin
      if (count_q == '0) size_d = bp_bedrock_msg_size_e'(in_size_i);

      if (count_q < max_cnt_lp) begin
        for (int k = 0; k < max_beats_lp; k++) begin
          if (count_q == cnt_width_lp'(k)) data_d[k*beat_width_p +: beat_width_p] = in_data_i;
        end
        count_d = count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end

      if (in_last_i) state_d = e_full;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_collect;
      count_q    <= '0;
      data_q     <= '0;
      size_q     <= e_bedrock_msg_size_1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      data_q     <= data_d;
      size_q     <= size_d;
      overflow_q <= overflow_d;
    end
  end

  // An empty buffer reports length 0 rather than wrapping to all ones.
  assign len_lo = (count_q == '0) ? '0 : len_width_lp'(count_q - 1'b1);

  bp_bedrock_len_to_size #(
    .beat_width_p (beat_width_p),
    .len_width_p  (len_width_lp)
  ) len_to_size (
    .len_i      (len_lo),
    .req_size_i (size_q),
    .size_o     (out_size_o)
  );

  assign out_data_o     = data_q;
  assign out_len_o      = len_lo;
  assign out_overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_bedrock_beat_packer.sv
// Randomized self-checking bench for bp_bedrock_beat_packer (64-bit beats, 512-bit buffer).
`default_nettype none

module tb_bp_bedrock_beat_packer;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [63:0]  in_data_i;
  logic [2:0]   in_size_i;
  logic         in_last_i;
  logic         in_v_i;
  logic         in_ready_and_o;
  logic [511:0] out_data_o;
  logic [2:0]   out_size_o;
  logic [2:0]   out_len_o;
  logic         out_overflow_o;
  logic         out_v_o;
  logic         out_ready_and_i;

  int n_vec = 0;
  int n_err = 0;

  logic [511:0] exp_data;
  logic [2:0]   exp_size;
  logic [2:0]   exp_len;
  logic         exp_ovf;

  bp_bedrock_beat_packer #(
    .beat_width_p     (64),
    .max_data_width_p (512)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .in_data_i       (in_data_i),
    .in_size_i       (in_size_i),
    .in_last_i       (in_last_i),
    .in_v_i          (in_v_i),
    .in_ready_and_o  (in_ready_and_o),
    .out_data_o      (out_data_o),
    .out_size_o      (out_size_o),
    .out_len_o       (out_len_o),
    .out_overflow_o  (out_overflow_o),
    .out_v_o         (out_v_o),
    .out_ready_and_i (out_ready_and_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_v"},    512'(out_v_o), 512'd0);
    check_eq({tag, "_rdy"},  512'(in_ready_and_o), 512'd1);
    check_eq({tag, "_data"}, out_data_o, 512'd0);
    check_eq({tag, "_size"}, 512'(out_size_o), 512'd0);
    check_eq({tag, "_len"},  512'(out_len_o), 512'd0);
    check_eq({tag, "_ovf"},  512'(out_overflow_o), 512'd0);
  endtask

  task automatic check_full(input string tag);
    check_eq({tag, "_v"},    512'(out_v_o), 512'd1);
    check_eq({tag, "_rdy"},  512'(in_ready_and_o), 512'd0);
    check_eq({tag, "_data"}, out_data_o, exp_data);
    check_eq({tag, "_size"}, 512'(out_size_o), 512'(exp_size));
    check_eq({tag, "_len"},  512'(out_len_o), 512'(exp_len));
    check_eq({tag, "_ovf"},  512'(out_overflow_o), 512'(exp_ovf));
  endtask

  // mode: 0 random data, 1 beat index as data, 2 fixed 0xDEADBEEF
  task automatic send_msg(input string tag, input int n, input logic [2:0] req, input int mode, input bit gaps);
    logic [63:0] beats[$];
    int stored;
    beats.delete();
    for (int b = 0; b < n; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_v_i    = 1'b0;
        in_data_i = {$urandom, $urandom};
        tick();
      end
      in_v_i    = 1'b1;
      in_last_i = (b == n - 1);
      in_size_i = (b == 0) ? req : 3'($urandom);
      case (mode)
        1:       in_data_i = 64'(b);
        2:       in_data_i = 64'hDEAD_BEEF;
        default: in_data_i = {$urandom, $urandom};
      endcase
      beats.push_back(in_data_i);
      check_eq({tag, "_accept"}, 512'(in_ready_and_o), 512'd1);
      tick();
    end
    in_v_i    = 1'b0;
    in_last_i = 1'b0;

    stored   = (n > 8) ? 8 : n;
    exp_data = '0;
    for (int k = 0; k < stored; k++) exp_data[k*64 +: 64] = beats[k];
    exp_len  = 3'(stored - 1);
    exp_ovf  = (n > 8);
    if (stored == 1) exp_size = (req > 3'd3) ? 3'd3 : req;
    else             exp_size = 3'($clog2(stored) + 3);
    check_full(tag);
  endtask

  // Hold the consumer off while offering beats, then take the message.
  task automatic drain(input string tag, input int hold);
    out_ready_and_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_v_i    = 1'b1;
      in_last_i = 1'($urandom);
      in_data_i = {$urandom, $urandom};
      tick();
      check_full({tag, "_hold"});
    end
    in_v_i          = 1'b1;
    in_last_i       = 1'b1;
    out_ready_and_i = 1'b1;
    tick();
    out_ready_and_i = 1'b0;
    in_v_i          = 1'b0;
    in_last_i       = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    reset_n_i       = 1'b0;
    in_data_i       = '0;
    in_size_i       = '0;
    in_last_i       = 1'b0;
    in_v_i          = 1'b0;
    out_ready_and_i = 1'b0;
    #12;
    check_idle("reset");
    reset_n_i = 1'b1;
    tick();
    check_idle("post_reset");

    send_msg("one_beat", 1, 3'd2, 2, 1'b0);
    drain("one_beat", 0);
    send_msg("clamp", 1, 3'd6, 0, 1'b0);
    drain("clamp", 1);
    send_msg("eight", 8, 3'd0, 1, 1'b0);
    drain("eight", 0);
    send_msg("three", 3, 3'd1, 0, 1'b0);
    drain("three", 0);
    send_msg("ten", 10, 3'd3, 1, 1'b0);
    drain("ten", 0);
    send_msg("bp", 4, 3'd3, 0, 1'b0);
    drain("bp", 5);
    send_msg("bp_next", 5, 3'd3, 0, 1'b0);
    drain("bp_next", 0);

    // Asynchronous reset in the middle of a partially collected message.
    send_msg_partial();
    #3;
    reset_n_i = 1'b0;
    #1;
    check_idle("async_rst");
    #3;
    reset_n_i = 1'b1;
    tick();
    check_idle("rst_release");
    send_msg("after_rst", 2, 3'd0, 0, 1'b0);
    drain("after_rst", 0);

    for (int m = 0; m < 40; m++) begin
      send_msg("rand", $urandom_range(1, 11), 3'($urandom), 0, 1'b1);
      drain("rand", $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic send_msg_partial();
    for (int b = 0; b < 2; b++) begin
      in_v_i    = 1'b1;
      in_last_i = 1'b0;
      in_size_i = 3'd3;
      in_data_i = {$urandom | 32'h1, $urandom};
      tick();
    end
    in_v_i = 1'b0;
    check_eq("partial_nonzero", 512'(out_data_o != '0), 512'd1);
  endtask

endmodule

`default_nettype wire

// File: doc/bp_bedrock_beat_packer.md
Name: bp_bedrock_beat_packer

Overview:
- Receives the data field of a BedRock message as a stream of fixed-width beats, with a last flag on the final beat.
- Packs the beats into a single wide message buffer.
- Derives the BedRock size field and zero-based length from the number of beats received.
- Sits at the receive side of any BedRock link whose data is serialized into beats, ahead of logic that consumes whole messages.

Parameters:
- beat_width_p, 64, bits per input data beat; power of two, at least 8.
- max_data_width_p, 512, bits in the packed output; a power-of-two multiple of beat_width_p, at most 1024.
- max_beats_lp (derived), max_data_width_p/beat_width_p.
- len_width_lp (derived), `BSG_SAFE_CLOG2(max_beats_lp).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- in_data_i  in  beat_width_p  data beat
- in_size_i  in  $bits(bp_bedrock_msg_size_e)  requested size; sampled on the first beat only
- in_last_i  in  1  marks the final beat of a message
- in_v_i  in  1  beat valid
- in_ready_and_o  out  1  beat accepted when in_v_i & in_ready_and_o
- out_data_o  out  max_data_width_p  packed data; beat k occupies [k*beat_width_p +: beat_width_p]
- out_size_o  out  $bits(bp_bedrock_msg_size_e)  derived message size
- out_len_o  out  len_width_lp  stored beats minus one
- out_overflow_o  out  1  set when more than max_beats_lp beats were offered
- out_v_o  out  1  packed message valid
- out_ready_and_i  in  1  consumer accepts when out_v_o & out_ready_and_i

Behaviour:
- Reset (asynchronous on reset_n_i low, regardless of clock):
  - state goes to e_collect; beat counter, buffer, stored size and overflow all clear to 0.
  - Resulting outputs: out_v_o=0, out_data_o=0, out_size_o=0, out_len_o=0, out_overflow_o=0, in_ready_and_o=1.
  - A partially collected message is discarded.
- State e_collect:
  - in_ready_and_o=1, out_v_o=0.
  - On each accepted beat with count < max_beats_lp: write the beat into slot count, then increment count.
  - On each accepted beat with count == max_beats_lp: drop the beat and set the overflow flag. The counter saturates.
  - On the first beat (count==0): capture in_size_i.
  - An accepted beat with in_last_i=1 moves the block to e_full.
- State e_full:
  - in_ready_and_o=0; out_v_o=1; outputs stay stable until the handshake.
  - On out_v_o & out_ready_and_i: clear buffer, counter, size and overflow, and return to e_collect.
  - No new beat is accepted in the handshake cycle. Throughput is N beats per N+1 cycles.
- Latency: out_v_o rises in the cycle after the last beat is accepted.
- out_len_o = stored beat count − 1, from the saturated count.
- Size derivation:
  - 1 stored beat: out_size_o = min(captured in_size_i, log2(beat_width_p/8)). Sub-beat sizes pass through; oversized requests are clamped.
  - n > 1 stored beats: out_size_o = clog2(n) + log2(beat_width_p/8). Non-power-of-two counts round up (3 beats → 4-beat size).
- Unfilled slots in out_data_o read 0.
- A single beat arriving with in_last_i=1 in e_collect completes a 1-beat message.
- in_v_i may fall mid-message; the count is retained and there is no timeout.

Decomposition:
- bp_bedrock_msg_size_e comes from bp_common_pkg; no new shared typedefs.
- The state enum {e_collect, e_full} is local to the module.
- One sub-module: bp_bedrock_len_to_size, a combinational encoder from beat count (len_width_lp) to bp_bedrock_msg_size_e, parameterised by beat_width_p. The packer instantiates it on the stored count.
- Counter and buffer are built from bsg_counter_clear_up and per-slot enables.

Test Plan (beat_width_p=64, max_data_width_p=512):
- 1 beat, in_size_i=e_bedrock_msg_size_4, data 0xDEADBEEF, last=1 → next cycle out_v_o=1; out_size_o=e_bedrock_msg_size_4; out_len_o=0; out_data_o[63:0]=0xDEADBEEF; all other bits 0.
- 1 beat with in_size_i=e_bedrock_msg_size_64 → out_size_o clamped to e_bedrock_msg_size_8.
- 8 beats with data 0..7, last on beat 8 → out_size_o=e_bedrock_msg_size_64; out_len_o=7; slot k holds value k; out_overflow_o=0.
- 3 beats → out_size_o=e_bedrock_msg_size_32; out_len_o=2; bits [511:192]=0.
- 10 beats → slots 0..7 hold beats 0..7; beats 8 and 9 dropped; out_overflow_o=1; out_len_o=7; out_size_o=e_bedrock_msg_size_64.
- Backpressure: after completing a message, hold out_ready_and_i=0 for 5 cycles while in_v_i=1 → in_ready_and_o=0 and outputs stable throughout. Then assert out_ready_and_i=1 → in_ready_and_o=1 the next cycle, and the next message collects correctly.
- Drive reset_n_i low asynchronously after 2 of 4 beats → all outputs 0 immediately. After release, a fresh 2-beat message gives out_size_o=e_bedrock_msg_size_16 and out_len_o=1.
